// File: rtl/branch_resolve_unit_if.sv
// Bundle for the branch resolve unit's fetch-side push channel, its execute-side
// resolve channel, the predictor training bus and the front-end flush/redirect.
//   pred_*      : fetch pushes a predicted branch (valid/ready handshake)
//   res_*       : execute resolves the oldest in-flight branch (valid/ready)
//   upd_*       : one-cycle training strobe towards the gshare predictor
//   flush_o     : mispredict flush pulse, redirect_pc_o the corrected next PC
//   count_o     : in-flight occupancy, mispredict_cnt_o saturating counter
// The slave modport is the unit's view and the master modport the environment's.
interface branch_resolve_unit_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned GHR_SIZE   = 4,
  parameter int unsigned IDX_BITS   = GHR_SIZE + 2,
  parameter int unsigned DEPTH      = 4
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic                  pred_valid_i;
  logic                  pred_ready_o;
  logic [ADDR_WIDTH-1:0] pred_pc_i;
  logic                  pred_taken_i;
  logic [ADDR_WIDTH-1:0] pred_target_i;
  logic [GHR_SIZE-1:0]   pred_ghr_i;

  logic                  res_valid_i;
  logic                  res_ready_o;
  logic                  res_taken_i;
  logic [ADDR_WIDTH-1:0] res_target_i;

  logic                  upd_valid_o;
  logic                  upd_taken_o;
  logic [IDX_BITS-1:0]   upd_index_o;
  logic [GHR_SIZE-1:0]   upd_ghr_o;

  logic                  flush_o;
  logic [ADDR_WIDTH-1:0] redirect_pc_o;
  logic [CntW-1:0]       count_o;
  logic [15:0]           mispredict_cnt_o;

  modport slave (
    input  pred_valid_i, pred_pc_i, pred_taken_i, pred_target_i, pred_ghr_i,
    input  res_valid_i, res_taken_i, res_target_i,
    output pred_ready_o, res_ready_o,
    output upd_valid_o, upd_taken_o, upd_index_o, upd_ghr_o,
    output flush_o, redirect_pc_o, count_o, mispredict_cnt_o
  );

  modport master (
    output pred_valid_i, pred_pc_i, pred_taken_i, pred_target_i, pred_ghr_i,
    output res_valid_i, res_taken_i, res_target_i,
    input  pred_ready_o, res_ready_o,
    input  upd_valid_o, upd_taken_o, upd_index_o, upd_ghr_o,
    input  flush_o, redirect_pc_o, count_o, mispredict_cnt_o
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: keeps the predictions issued at fetch in an in-order
// in-flight queue, pairs the oldest one with the outcome from execute, trains the
// gshare predictor and, on a misprediction, flushes/redirects the front end.
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset, discards all in-flight entries
//   bru_io : branch_resolve_unit_if slave (push, resolve, training, flush, status)
// All outputs except the two ready signals are registered and appear one cycle
// after the resolve handshake.
module branch_resolve_unit #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned GHR_SIZE   = 4,
  parameter int unsigned IDX_BITS   = GHR_SIZE + 2,
  parameter int unsigned DEPTH      = 4
) (
  input logic                   clk,
  input logic                   rst,
  branch_resolve_unit_if.slave  bru_io
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {StNormal, StFlush} state_e;

  state_e                state_q;
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;

  // Entry storage needs no reset: occupancy is tracked by the pointers/count.
  logic [ADDR_WIDTH-1:0] pc_q     [DEPTH];
  logic [ADDR_WIDTH-1:0] target_q [DEPTH];
  logic [GHR_SIZE-1:0]   ghr_q    [DEPTH];
  logic [DEPTH-1:0]      taken_q;

  logic                  upd_valid_q, upd_taken_q, flush_q;
  logic [IDX_BITS-1:0]   upd_index_q;
  logic [GHR_SIZE-1:0]   upd_ghr_q;
  logic [ADDR_WIDTH-1:0] redirect_q, redirect_d;
  logic [15:0]           mis_cnt_q, mis_cnt_d;

  logic                  full, empty, pred_ready, res_ready, push, pop, mispredict;
  logic [ADDR_WIDTH-1:0] head_pc, head_target;
  logic [GHR_SIZE-1:0]   head_ghr;
  logic                  head_taken;

  always_comb begin
    full        = (count_q == CntW'(DEPTH));
    empty       = (count_q == '0);
    pred_ready  = !full && (state_q == StNormal);
    res_ready   = !empty && (state_q == StNormal);
    push        = bru_io.pred_valid_i && pred_ready;
    pop         = bru_io.res_valid_i && res_ready;

    head_pc     = pc_q[rd_ptr_q];
    head_target = target_q[rd_ptr_q];
    head_ghr    = ghr_q[rd_ptr_q];
    head_taken  = taken_q[rd_ptr_q];

    // A taken branch also mispredicts when it went somewhere other than predicted.
    mispredict  = pop && ((bru_io.res_taken_i != head_taken) ||
                          (bru_io.res_taken_i && (bru_io.res_target_i != head_target)));

    redirect_d  = bru_io.res_taken_i ? bru_io.res_target_i : head_pc + ADDR_WIDTH'(4);
    mis_cnt_d   = (mis_cnt_q == 16'hFFFF) ? mis_cnt_q : mis_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr_q]     <= bru_io.pred_pc_i;
      target_q[wr_ptr_q] <= bru_io.pred_target_i;
      ghr_q[wr_ptr_q]    <= bru_io.pred_ghr_i;
      taken_q[wr_ptr_q]  <= bru_io.pred_taken_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StNormal;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      upd_valid_q <= 1'b0;
      upd_taken_q <= 1'b0;
      upd_index_q <= '0;
      upd_ghr_q   <= '0;
      flush_q     <= 1'b0;
      redirect_q  <= '0;
      mis_cnt_q   <= '0;
    end else begin
      upd_valid_q <= pop;
      flush_q     <= mispredict;
      if (pop) begin
        upd_taken_q <= bru_io.res_taken_i;
        upd_index_q <= {head_ghr, head_pc[1:0]};
        upd_ghr_q   <= {head_ghr[GHR_SIZE-2:0], bru_io.res_taken_i};
      end
      if (mispredict) begin
        // Everything younger is wrong-path, including a same-cycle push.
        state_q    <= StFlush;
        redirect_q <= redirect_d;
        mis_cnt_q  <= mis_cnt_d;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
      end else begin
        state_q <= StNormal;
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        if (push && !pop)      count_q <= count_q + CntW'(1);
        else if (!push && pop) count_q <= count_q - CntW'(1);
      end
    end
  end

  assign bru_io.pred_ready_o     = pred_ready;
  assign bru_io.res_ready_o      = res_ready;
  assign bru_io.upd_valid_o      = upd_valid_q;
  assign bru_io.upd_taken_o      = upd_taken_q;
  assign bru_io.upd_index_o      = upd_index_q;
  assign bru_io.upd_ghr_o        = upd_ghr_q;
  assign bru_io.flush_o          = flush_q;
  assign bru_io.redirect_pc_o    = redirect_q;
  assign bru_io.count_o          = count_q;
  assign bru_io.mispredict_cnt_o = mis_cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: a reference queue model predicts
// readies, occupancy and the training/flush results; expected training results
// are queued at the resolve handshake and compared when the DUT strobes upd_valid_o.
module tb_branch_resolve_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.ADDR_WIDTH(32), .GHR_SIZE(4), .IDX_BITS(6), .DEPTH(4)) bus_if ();

  branch_resolve_unit #(.ADDR_WIDTH(32), .GHR_SIZE(4), .IDX_BITS(6), .DEPTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .bru_io (bus_if)
  );

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] tgt;
    logic [3:0]  ghr;
  } ent_t;

  typedef struct {
    logic        taken;
    logic [5:0]  idx;
    logic [3:0]  ghr;
    logic        flush;
    logic [31:0] redir;
    logic [15:0] mcnt;
  } exp_t;

  ent_t        mq[$];
  exp_t        sb[$];
  exp_t        mon_e;
  bit          m_flush = 1'b0;
  logic [31:0] m_redir = '0;
  logic [15:0] m_mcnt  = '0;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
  endtask

  function automatic ent_t mk(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                              input logic [3:0] ghr);
    ent_t e;
    e.pc = pc; e.taken = tk; e.tgt = tgt; e.ghr = ghr;
    return e;
  endfunction

  // One clock cycle of stimulus; called #1 after a rising edge.
  task automatic step(input bit pv, input ent_t pe, input bit rv, input logic rt,
                      input logic [31:0] rtgt);
    bit   exp_pr, exp_rr, do_push, do_pop, mis;
    ent_t h;
    exp_t e;
    bus_if.pred_valid_i  = pv;
    bus_if.pred_pc_i     = pe.pc;
    bus_if.pred_taken_i  = pe.taken;
    bus_if.pred_target_i = pe.tgt;
    bus_if.pred_ghr_i    = pe.ghr;
    bus_if.res_valid_i   = rv;
    bus_if.res_taken_i   = rt;
    bus_if.res_target_i  = rtgt;
    exp_pr  = (mq.size() < 4) && !m_flush;
    exp_rr  = (mq.size() > 0) && !m_flush;
    #1;
    check("pred_ready", 32'(bus_if.pred_ready_o), 32'(exp_pr));
    check("res_ready", 32'(bus_if.res_ready_o), 32'(exp_rr));
    do_push = pv && exp_pr;
    do_pop  = rv && exp_rr;
    mis     = 1'b0;
    if (do_pop) begin
      h   = mq[0];
      mis = (rt != h.taken) || (rt && (rtgt != h.tgt));
      if (mis) begin
        m_redir = rt ? rtgt : h.pc + 32'd4;
        if (m_mcnt != 16'hFFFF) m_mcnt = m_mcnt + 16'd1;
      end
      e.taken = rt;
      e.idx   = {h.ghr, h.pc[1:0]};
      e.ghr   = {h.ghr[2:0], rt};
      e.flush = mis;
      e.redir = m_redir;
      e.mcnt  = m_mcnt;
      sb.push_back(e);
      void'(mq.pop_front());
    end
    if (mis) mq.delete();
    else if (do_push) mq.push_back(pe);
    @(posedge clk);
    #1;
    m_flush = mis;
    bus_if.pred_valid_i = 1'b0;
    bus_if.res_valid_i  = 1'b0;
    check("count", 32'(bus_if.count_o), 32'(mq.size()));
  endtask

  task automatic idle();
    step(1'b0, mk(0, 0, 0, 0), 1'b0, 1'b0, 0);
  endtask

  // Scoreboard consumer: compares each training strobe with the queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.upd_valid_o) begin
        if (sb.size() == 0) begin
          check("upd_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("upd_taken", 32'(bus_if.upd_taken_o), 32'(mon_e.taken));
          check("upd_index", 32'(bus_if.upd_index_o), 32'(mon_e.idx));
          check("upd_ghr", 32'(bus_if.upd_ghr_o), 32'(mon_e.ghr));
          check("flush", 32'(bus_if.flush_o), 32'(mon_e.flush));
          check("redirect_pc", bus_if.redirect_pc_o, mon_e.redir);
          check("mispredict_cnt", 32'(bus_if.mispredict_cnt_o), 32'(mon_e.mcnt));
        end
      end else if (bus_if.flush_o) begin
        check("flush_without_upd", 32'd1, 32'd0);
      end
    end
  end

  initial begin
    bus_if.pred_valid_i  = 1'b0;
    bus_if.pred_pc_i     = '0;
    bus_if.pred_taken_i  = 1'b0;
    bus_if.pred_target_i = '0;
    bus_if.pred_ghr_i    = '0;
    bus_if.res_valid_i   = 1'b0;
    bus_if.res_taken_i   = 1'b0;
    bus_if.res_target_i  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(bus_if.count_o), 32'd0);
    check("rst_upd_valid", 32'(bus_if.upd_valid_o), 32'd0);
    check("rst_flush", 32'(bus_if.flush_o), 32'd0);
    check("rst_redirect", bus_if.redirect_pc_o, 32'd0);
    check("rst_mcnt", 32'(bus_if.mispredict_cnt_o), 32'd0);
    check("rst_index", 32'(bus_if.upd_index_o), 32'd0);
    rst = 1'b0;

    // Correct prediction: index {1010,00}, new GHR 0101.
    step(1'b1, mk(32'h100, 1'b1, 32'h200, 4'b1010), 1'b0, 1'b0, 0);
    step(1'b0, mk(0, 0, 0, 0), 1'b1, 1'b1, 32'h200);
    idle();

    // Predicted not-taken, actually taken to 0x300.
    step(1'b1, mk(32'h104, 1'b0, 32'h0, 4'b0000), 1'b0, 1'b0, 0);
    step(1'b0, mk(0, 0, 0, 0), 1'b1, 1'b1, 32'h300);
    idle();   // FLUSH cycle: readies low
    idle();

    // Predicted taken, actually not taken: redirect pc+4.
    step(1'b1, mk(32'h108, 1'b1, 32'h400, 4'b0110), 1'b0, 1'b0, 0);
    step(1'b0, mk(0, 0, 0, 0), 1'b1, 1'b0, 32'h0);
    idle();
    idle();

    // Fill to full, try a fifth push, then drain in order.
    for (int i = 0; i < 4; i++)
      step(1'b1, mk(32'h200 + 32'(i), 1'b1, 32'h800 + 32'(i), 4'(i * 3)), 1'b0, 1'b0, 0);
    step(1'b1, mk(32'h2F0, 1'b0, 32'h0, 4'hF), 1'b0, 1'b0, 0);
    for (int i = 0; i < 4; i++)
      step(1'b0, mk(0, 0, 0, 0), 1'b1, 1'b1, 32'h800 + 32'(i));
    idle();

    // Two queued, then same-cycle push and mispredicting resolve.
    step(1'b1, mk(32'h300, 1'b0, 32'h0, 4'b0011), 1'b0, 1'b0, 0);
    step(1'b1, mk(32'h305, 1'b1, 32'h500, 4'b1100), 1'b0, 1'b0, 0);
    step(1'b1, mk(32'h30A, 1'b1, 32'h600, 4'b0001), 1'b1, 1'b1, 32'h700);
    idle();
    idle();

    // Reset with three entries in flight.
    for (int i = 0; i < 3; i++)
      step(1'b1, mk(32'h400 + 32'(4 * i), 1'b0, 32'h0, 4'(i)), 1'b0, 1'b0, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_count", 32'(bus_if.count_o), 32'd0);
    check("mid_rst_redirect", bus_if.redirect_pc_o, 32'd0);
    check("mid_rst_mcnt", 32'(bus_if.mispredict_cnt_o), 32'd0);
    check("mid_rst_flush", 32'(bus_if.flush_o), 32'd0);
    check("mid_rst_upd_valid", 32'(bus_if.upd_valid_o), 32'd0);
    mq.delete();
    m_flush = 1'b0;
    m_redir = '0;
    m_mcnt  = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();

    // Random traffic, mostly correct resolutions.
    for (int n = 0; n < 300; n++) begin
      ent_t pe;
      logic rt;
      logic [31:0] rtgt;
      pe = mk($urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom));
      if (mq.size() > 0 && $urandom_range(0, 9) < 7) begin
        rt   = mq[0].taken;
        rtgt = mq[0].tgt;
      end else begin
        rt   = 1'($urandom_range(0, 1));
        rtgt = $urandom;
      end
      step(1'($urandom_range(0, 1)), pe, 1'($urandom_range(0, 1)), rt, rtgt);
    end
    idle();
    idle();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Counterpart to the gshare predictor controller. It records each prediction issued at fetch in an in-order in-flight queue, pairs it with the branch outcome from execute, and drives the predictor training bus (taken, counter index, new GHR). On a misprediction it drives the front-end flush/redirect and GHR recovery.

Parameters:
ADDR_WIDTH, 32, PC/target width
GHR_SIZE, 4, global history length in bits
IDX_BITS, GHR_SIZE+2, counter-table index width
DEPTH, 4, in-flight queue entries (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
pred_valid_i  in  1  fetch pushes a predicted branch
pred_ready_o  out  1  queue can accept; equals !full && state==NORMAL
pred_pc_i  in  ADDR_WIDTH  branch PC
pred_taken_i  in  1  predicted direction
pred_target_i  in  ADDR_WIDTH  predicted target
pred_ghr_i  in  GHR_SIZE  GHR snapshot used for the prediction
res_valid_i  in  1  execute presents outcome of oldest branch
res_ready_o  out  1  equals !empty && state==NORMAL
res_taken_i  in  1  actual direction
res_target_i  in  ADDR_WIDTH  actual target
upd_valid_o  out  1  training strobe to predictor (is_branch/update)
upd_taken_o  out  1  actual direction
upd_index_o  out  IDX_BITS  {ghr_snapshot, pc[1:0]}
upd_ghr_o  out  GHR_SIZE  {ghr_snapshot[GHR_SIZE-2:0], res_taken}
flush_o  out  1  mispredict flush pulse
redirect_pc_o  out  ADDR_WIDTH  correct next PC
count_o  out  $clog2(DEPTH)+1  occupied entries
mispredict_cnt_o  out  16  saturating mispredict counter

Behaviour:
- Reset (async, rst=1): queue empty, pointers 0, state NORMAL, upd_valid_o=0, upd_taken_o=0, upd_index_o=0, upd_ghr_o=0, flush_o=0, redirect_pc_o=0, count_o=0, mispredict_cnt_o=0. Asserting rst mid-operation discards all in-flight entries immediately.
- Push: pred_valid_i && pred_ready_o stores {pc, taken, target, ghr} at the tail.
- Resolve: res_valid_i && res_ready_o pops the head. Resolutions arrive strictly in program order; no ID matching.
- Mispredict = (res_taken != head.taken) || (res_taken && res_target != head.target).
- All outputs registered; one-cycle latency from the resolve handshake:
  - upd_valid_o pulses one cycle for every resolve, correct or not, carrying upd_taken_o, upd_index_o and upd_ghr_o.
  - On mispredict, flush_o pulses in the same cycle as upd_valid_o.
  - redirect_pc_o = res_target if taken, else head.pc+4 (mod 2^ADDR_WIDTH). It holds its value until the next mispredict.
- FSM:
  - NORMAL -> FLUSH on a mispredicting resolve.
  - FLUSH (exactly 1 cycle, flush_o=1): queue cleared, pred_ready_o=0, res_ready_o=0.
  - FLUSH -> NORMAL unconditionally.
- Simultaneous push and resolve in NORMAL:
  - No mispredict: both occur, count unchanged.
  - Mispredict: the push is discarded (younger, wrong path) and the queue ends empty.
- Full: pred_ready_o=0; a push attempted while full is ignored with no state change. Empty: res_ready_o=0; res_valid_i is ignored.
- Pointers wrap modulo DEPTH. count_o runs 0..DEPTH.
- mispredict_cnt_o increments on each mispredict and saturates at 16'hFFFF.

Test Plan:
- Reset then push pc=0x100, taken=1, target=0x200, ghr=4'b1010; resolve taken=1, target=0x200 -> next cycle upd_valid_o=1, upd_index_o=6'b101000, upd_ghr_o=4'b0101, flush_o=0, count_o=0.
- Push pc=0x104, taken=0, ghr=0; resolve taken=1, target=0x300 -> flush_o=1, redirect_pc_o=0x300, upd_taken_o=1, mispredict_cnt_o=1. Next cycle pred_ready_o=0, then 1.
- Push pc=0x108, taken=1, target=0x400; resolve taken=0 -> redirect_pc_o=0x10C, flush_o=1.
- Push 4 entries -> count_o=4, pred_ready_o=0. 5th push held, no change. Resolve all 4 correctly -> four upd_valid_o pulses in order, count_o=0, res_ready_o=0.
- With 2 queued, same cycle: push new and resolve head mispredicted -> after FLUSH, count_o=0 and the new entry is absent.
- Assert rst with 3 entries queued -> all outputs 0 immediately, count_o=0.
